// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multiply/divide unit: latches a DX mul/div, pulses the unit,
// stalls the front end until the result arrives, then emits one writeback beat.
module multdiv_ctrl #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mul,
    input  logic        start_div,
    input  logic        flush,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  op_rd,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [4:0]       STATUS_REG = 5'd30;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MAX_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       opA_q, opA_d;
    logic [31:0]       opB_q, opB_d;
    logic [4:0]        rd_q, rd_d;
    logic              isDiv_q, isDiv_d;
    logic              pulseMul_q, pulseMul_d;
    logic              pulseDiv_q, pulseDiv_d;
    logic              wbValid_q, wbValid_d;
    logic [4:0]        wbReg_q, wbReg_d;
    logic [31:0]       wbData_q, wbData_d;
    logic              timeout_q, timeout_d;
    logic              start;

    // Both start lines high is a malformed decode and is treated as no request.
    assign start = start_mul ^ start_div;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        rd_d       = rd_q;
        isDiv_d    = isDiv_q;
        pulseMul_d = 1'b0;
        pulseDiv_d = 1'b0;
        wbValid_d  = 1'b0;
        wbReg_d    = wbReg_q;
        wbData_d   = wbData_q;
        timeout_d  = timeout_q;
        stall      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    opA_d      = op_a;
                    opB_d      = op_b;
                    rd_d       = op_rd;
                    isDiv_d    = start_div;
                    cnt_d      = '0;
                    pulseMul_d = start_mul;
                    pulseDiv_d = start_div;
                    stall      = 1'b1;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (flush) begin
                    state_d = IDLE;
                end else if (md_ready) begin
                    state_d   = DONE;
                    wbValid_d = 1'b1;
                    if (md_exception) begin
                        wbReg_d  = STATUS_REG;
                        wbData_d = isDiv_q ? 32'd5 : 32'd4;
                    end else begin
                        wbReg_d  = rd_q;
                        wbData_d = md_result;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Watchdog expiry is reported like a unit exception.
                    state_d   = DONE;
                    wbValid_d = 1'b1;
                    wbReg_d   = STATUS_REG;
                    wbData_d  = isDiv_q ? 32'd5 : 32'd4;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            opA_q      <= '0;
            opB_q      <= '0;
            rd_q       <= '0;
            isDiv_q    <= 1'b0;
            pulseMul_q <= 1'b0;
            pulseDiv_q <= 1'b0;
            wbValid_q  <= 1'b0;
            wbReg_q    <= '0;
            wbData_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            rd_q       <= rd_d;
            isDiv_q    <= isDiv_d;
            pulseMul_q <= pulseMul_d;
            pulseDiv_q <= pulseDiv_d;
            wbValid_q  <= wbValid_d;
            wbReg_q    <= wbReg_d;
            wbData_q   <= wbData_d;
            timeout_q  <= timeout_d;
        end
    end

    assign md_a      = opA_q;
    assign md_b      = opB_q;
    assign ctrl_MULT = pulseMul_q;
    assign ctrl_DIV  = pulseDiv_q;
    assign wb_valid  = wbValid_q;
    assign wb_reg    = wbReg_q;
    assign wb_data   = wbData_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Testbench for multdiv_ctrl: directed operations against a simple multdiv latency model,
// with expected writeback beats queued at issue and checked by a separate monitor.
module tb_multdiv_ctrl;

    typedef struct {
        logic [4:0]  wbReg;
        logic [31:0] data;
        int          cycle;
    } wbExp_t;

    logic        clock;
    logic        reset;
    logic        start_mul;
    logic        start_div;
    logic        flush;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  op_rd;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        timeout;

    int          testsRun = 0;
    int          testsFailed = 0;
    int          cyc = 0;
    int          mulPulses = 0;
    int          divPulses = 0;
    int          wbBeats = 0;
    wbExp_t      sbQ[$];

    int          mdLatency = 0;
    int          mdCnt = 0;
    logic [31:0] mdResultCfg = '0;
    logic        mdExcCfg = 1'b0;
    logic        modelReady = 1'b0;
    logic        forceReady = 1'b0;

    multdiv_ctrl #(.MAX_CYCLES(40), .CNT_W(6)) dut (
        .clock(clock),
        .reset(reset),
        .start_mul(start_mul),
        .start_div(start_div),
        .flush(flush),
        .op_a(op_a),
        .op_b(op_b),
        .op_rd(op_rd),
        .md_result(md_result),
        .md_exception(md_exception),
        .md_ready(md_ready),
        .md_a(md_a),
        .md_b(md_b),
        .ctrl_MULT(ctrl_MULT),
        .ctrl_DIV(ctrl_DIV),
        .stall(stall),
        .wb_valid(wb_valid),
        .wb_reg(wb_reg),
        .wb_data(wb_data),
        .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Multdiv model: md_ready pulses mdLatency cycles after the start pulse; 0 means never.
    always @(negedge clock) begin
        if (!reset) begin
            mdCnt      <= 0;
            modelReady <= 1'b0;
        end else begin
            modelReady <= 1'b0;
            if (ctrl_MULT || ctrl_DIV) begin
                mdCnt <= mdLatency;
            end else if (mdCnt != 0) begin
                mdCnt <= mdCnt - 1;
                if (mdCnt == 1) modelReady <= 1'b1;
            end
        end
    end

    assign md_ready     = modelReady | forceReady;
    assign md_result    = mdResultCfg;
    assign md_exception = mdExcCfg;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic mul, input logic div, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd);
        start_mul = mul;
        start_div = div;
        op_a      = a;
        op_b      = b;
        op_rd     = rd;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic monitor();
        wbExp_t e;
        forever begin
            @(negedge clock);
            if (ctrl_MULT) mulPulses++;
            if (ctrl_DIV) divPulses++;
            if (wb_valid) begin
                wbBeats++;
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_wb_pending", sbQ.size(), 1);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("wb_reg", {27'd0, wb_reg}, {27'd0, e.wbReg});
                    checkOutput("wb_data", wb_data, e.data);
                    checkOutput("wb_cycle", cyc, e.cycle);
                end
            end
        end
    endtask

    initial begin
        int s;
        int stallLow;
        reset      = 1'b0;
        flush      = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        fork
            monitor();
        join_none

        // Reset values
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_wb_valid", {31'd0, wb_valid}, 0);
        checkOutput("rst_stall", {31'd0, stall}, 0);
        checkOutput("rst_pulses", {30'd0, ctrl_MULT, ctrl_DIV}, 0);
        checkOutput("rst_md_a", md_a, 0);
        checkOutput("rst_md_b", md_b, 0);
        checkOutput("rst_wb_reg", {27'd0, wb_reg}, 0);
        checkOutput("rst_wb_data", wb_data, 0);
        checkOutput("rst_timeout", {31'd0, timeout}, 0);
        nextCycle();
        reset = 1'b1;
        repeat (2) nextCycle();

        // Normal multiply: 7*6 into r3, result 16 cycles after the pulse
        mdLatency = 16; mdResultCfg = 32'd42; mdExcCfg = 1'b0;
        nextCycle();
        s = cyc;
        sbQ.push_back('{5'd3, 32'd42, s + 18});
        applyStimulus(1, 0, 32'd7, 32'd6, 5'd3);
        @(negedge clock);
        checkOutput("mul_stall_start", {31'd0, stall}, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("mul_pulse", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd2);
        checkOutput("mul_md_a", md_a, 32'd7);
        checkOutput("mul_md_b", md_b, 32'd6);
        stallLow = 0;
        repeat (16) begin
            nextCycle();
            @(negedge clock);
            if (!stall) stallLow++;
        end
        checkOutput("mul_busy_stall_gaps", stallLow, 0);
        nextCycle();
        @(negedge clock);
        checkOutput("mul_done_stall", {31'd0, stall}, 0);
        checkOutput("mul_done_valid", {31'd0, wb_valid}, 1);
        nextCycle();
        @(negedge clock);
        checkOutput("mul_valid_drop", {31'd0, wb_valid}, 0);
        checkOutput("mul_wb_reg_hold", {27'd0, wb_reg}, 32'd3);
        checkOutput("mul_wb_data_hold", wb_data, 32'd42);
        checkOutput("mul_pulse_count", mulPulses, 1);

        // Divide by zero: unit exception redirects to r30 with code 5
        mdLatency = 5; mdResultCfg = 32'hDEAD; mdExcCfg = 1'b1;
        nextCycle();
        s = cyc;
        sbQ.push_back('{5'd30, 32'd5, s + 7});
        applyStimulus(0, 1, 32'd9, 32'd0, 5'd5);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("div_pulse", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd1);
        repeat (8) nextCycle();
        mdExcCfg = 1'b0;
        checkOutput("div_timeout", {31'd0, timeout}, 0);
        checkOutput("div_pulse_count", divPulses, 1);
        checkOutput("div_mul_count", mulPulses, 1);
        checkOutput("div_beats", wbBeats, 2);

        // Watchdog: unit never answers, abort after 40 busy cycles
        mdLatency = 0;
        nextCycle();
        s = cyc;
        sbQ.push_back('{5'd30, 32'd4, s + 41});
        applyStimulus(1, 0, 32'd1, 32'd2, 5'd7);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        repeat (39) nextCycle();
        @(negedge clock);
        checkOutput("wd_last_busy_timeout", {31'd0, timeout}, 0);
        checkOutput("wd_last_busy_stall", {31'd0, stall}, 1);
        nextCycle();
        @(negedge clock);
        checkOutput("wd_done_valid", {31'd0, wb_valid}, 1);
        checkOutput("wd_timeout_set", {31'd0, timeout}, 1);
        nextCycle();
        forceReady = 1'b1;
        @(negedge clock);
        checkOutput("wd_idle_stall", {31'd0, stall}, 0);
        nextCycle();
        forceReady = 1'b0;
        repeat (3) nextCycle();
        checkOutput("wd_timeout_sticky", {31'd0, timeout}, 1);
        checkOutput("wd_late_ready_beats", wbBeats, 3);

        // Flush on busy cycle 5; the later md_ready must be discarded
        mdLatency = 32;
        nextCycle();
        applyStimulus(0, 1, 32'd100, 32'd3, 5'd8);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        repeat (4) nextCycle();
        flush = 1'b1;
        @(negedge clock);
        checkOutput("flush_cycle_stall", {31'd0, stall}, 1);
        nextCycle();
        flush = 1'b0;
        @(negedge clock);
        checkOutput("flush_after_stall", {31'd0, stall}, 0);
        repeat (32) nextCycle();
        checkOutput("flush_beats", wbBeats, 3);
        checkOutput("flush_div_count", divPulses, 2);
        checkOutput("flush_idle_stall", {31'd0, stall}, 0);

        // flush and md_ready in the same busy cycle
        mdLatency = 4;
        nextCycle();
        applyStimulus(1, 0, 32'd5, 32'd5, 5'd9);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        repeat (4) nextCycle();
        flush = 1'b1;
        nextCycle();
        flush = 1'b0;
        @(negedge clock);
        checkOutput("flush_ready_valid", {31'd0, wb_valid}, 0);
        checkOutput("flush_ready_stall", {31'd0, stall}, 0);
        repeat (3) nextCycle();
        checkOutput("flush_ready_beats", wbBeats, 3);

        // Both start lines high is not a request
        nextCycle();
        applyStimulus(1, 1, 32'd1, 32'd1, 5'd1);
        @(negedge clock);
        checkOutput("both_stall", {31'd0, stall}, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("both_pulse", {30'd0, ctrl_MULT, ctrl_DIV}, 0);

        // Reset mid-busy aborts and clears everything, including timeout
        mdLatency = 0;
        nextCycle();
        applyStimulus(1, 0, 32'd11, 32'd12, 5'd4);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        repeat (2) nextCycle();
        reset = 1'b0;
        nextCycle();
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midrst_md_a", md_a, 0);
        checkOutput("midrst_md_b", md_b, 0);
        checkOutput("midrst_stall", {31'd0, stall}, 0);
        checkOutput("midrst_timeout", {31'd0, timeout}, 0);
        checkOutput("midrst_wb_reg", {27'd0, wb_reg}, 0);
        checkOutput("midrst_wb_data", wb_data, 0);
        repeat (5) nextCycle();
        checkOutput("midrst_beats", wbBeats, 3);
        checkOutput("midrst_mul_count", mulPulses, 4);

        // Back-to-back muls with DX start held through DONE
        mdLatency = 3; mdResultCfg = 32'd100;
        nextCycle();
        s = cyc;
        sbQ.push_back('{5'd2, 32'd100, s + 5});
        applyStimulus(1, 0, 32'd10, 32'd10, 5'd2);
        repeat (5) nextCycle();
        @(negedge clock);
        checkOutput("b2b_done_stall", {31'd0, stall}, 0);
        nextCycle();
        applyStimulus(1, 0, 32'd20, 32'd20, 5'd6);
        mdResultCfg = 32'd200;
        sbQ.push_back('{5'd6, 32'd200, s + 11});
        @(negedge clock);
        checkOutput("b2b_accept_stall", {31'd0, stall}, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("b2b_pulse2", {31'd0, ctrl_MULT}, 1);
        checkOutput("b2b_md_a2", md_a, 32'd20);
        repeat (6) nextCycle();
        checkOutput("b2b_mul_count", mulPulses, 6);
        checkOutput("b2b_beats", wbBeats, 5);
        checkOutput("sb_drained", sbQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencer for the shared multiply/divide unit in the 5-stage pipeline. It accepts a mul/div instruction from the DX stage and latches its operands and destination. It fires the single-cycle ctrl_MULT/ctrl_DIV pulse, stalls the front of the pipeline until the unit reports ready, then presents one writeback beat to the MW path. Exceptions and watchdog timeouts are redirected to $rstatus.

## Interface
- MAX_CYCLES, 40: busy cycles allowed before the watchdog aborts the operation.
- CNT_W, 6: watchdog counter width; must hold MAX_CYCLES.
- clock  in  1  master clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising edge of clock.
- start_mul  in  1  DX holds a mul instruction.
- start_div  in  1  DX holds a div instruction.
- flush  in  1  kill any in-flight operation (branch/jump squash).
- op_a  in  32  DX operand A (bypassed value).
- op_b  in  32  DX operand B (bypassed value).
- op_rd  in  5  destination register of the DX instruction.
- md_result  in  32  multdiv data_result.
- md_exception  in  1  multdiv data_exception.
- md_ready  in  1  multdiv data_resultRDY.
- md_a  out  32  latched operand A to multdiv.
- md_b  out  32  latched operand B to multdiv.
- ctrl_MULT  out  1  one-cycle start pulse to multdiv.
- ctrl_DIV  out  1  one-cycle start pulse to multdiv.
- stall  out  1  freeze PC, FD, DX; insert bubble into XM.
- wb_valid  out  1  one-cycle writeback beat.
- wb_reg  out  5  writeback register.
- wb_data  out  32  writeback data.
- timeout  out  1  sticky watchdog flag, cleared only by reset.

## Operation
- States: IDLE, BUSY, DONE.
- A start is a cycle where start_mul XOR start_div is 1. If both are 1, the block treats it as no start and does not assert stall.
- IDLE + start + !flush:
  - Latch op_a, op_b, op_rd and the op type.
  - Clear the counter. Go to BUSY.
- BUSY:
  - Counter increments each cycle.
  - flush → IDLE, no writeback; the pending md_ready is discarded.
  - Otherwise md_ready → DONE. Capture md_result and md_exception.
  - Otherwise counter == MAX_CYCLES-1 → DONE as an exception, and set timeout.
- DONE:
  - Always → IDLE.
  - start is ignored, because the originating instruction is still in DX this cycle.
- md_ready and md_exception are ignored in IDLE and DONE.
- Priority in BUSY: flush > md_ready > watchdog.
- Writeback on normal completion: wb_reg = latched rd, wb_data = md_result.
- Writeback on exception or timeout: wb_reg = 30.
  - wb_data = 4 for mul.
  - wb_data = 5 for div.
- rd = 0 still produces wb_valid. The regfile ignores writes to r0.

## Timing
- Reset values: state IDLE, md_a = md_b = 0, ctrl_MULT = ctrl_DIV = 0, stall = 0, wb_valid = 0, wb_reg = 0, wb_data = 0, timeout = 0, counter = 0.
- Reset while BUSY aborts the operation with no writeback and clears timeout.
- stall (combinational) = (IDLE & start & !flush) | BUSY. It is 0 in DONE, which lets the instruction advance.
- ctrl_MULT/ctrl_DIV are registered and high only during the first BUSY cycle. md_a and md_b are stable from that cycle until the next accept.
- Latency: start is sampled at edge 0, the pulse occurs in cycle 1, md_ready is sampled at edge k, and wb_valid is high for exactly one cycle (cycle k+1, the DONE cycle).
- wb_reg and wb_data are registered and hold their values after wb_valid drops.
- Back-to-back: a new start is accepted in the IDLE cycle that follows DONE. The minimum spacing between pulses is 3 cycles plus unit latency.

## Test plan
- Mul:
  - Stimulus: start_mul, op_a = 7, op_b = 6, rd = 3; model md_ready 16 cycles after the pulse with result 42.
  - Required response: one ctrl_MULT pulse; stall high from the start cycle through BUSY; wb_valid for one cycle with wb_reg = 3, wb_data = 42.
- Div exception:
  - Stimulus: start_div, op_a = 9, op_b = 0, rd = 5; md_exception = 1 with md_ready.
  - Required response: wb_reg = 30, wb_data = 5; ctrl_DIV pulse only; timeout stays 0.
- Watchdog:
  - Stimulus: start_mul; md_ready never asserts.
  - Required response: after MAX_CYCLES = 40 BUSY cycles, DONE with wb_reg = 30, wb_data = 4; timeout = 1 and stays 1; a later md_ready is ignored.
- Flush:
  - Stimulus: start_div, flush on BUSY cycle 5, then md_ready at cycle 33.
  - Required response: no wb_valid; stall drops the cycle after flush; state IDLE.
- Simultaneous events:
  - flush and md_ready in the same BUSY cycle → no writeback.
  - start_mul and start_div both high in IDLE → no pulse, stall = 0.
- Reset and back-to-back:
  - reset low for one cycle mid-BUSY → all outputs at reset values on the next cycle.
  - Two consecutive muls (DX start held through DONE) → exactly two pulses, two wb beats, no double issue.
